// File: rtl/ps2_pkg.sv
// ps2_pkg: types and constants shared by the PS/2 mouse receiver and the
// downstream 7-segment/LED control stage.
//   frame_state_t   : frame deserialiser states
//   PS2_DATA_BITS   : data bits per PS/2 frame
//   PKT_*_LSB       : field offsets inside the 24-bit mouse packet
//   SYNC_BIT        : bit of the status byte that is always 1
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  localparam int unsigned PS2_DATA_BITS  = 8;
  localparam int unsigned PKT_W          = 24;
  localparam int unsigned PKT_STATUS_LSB = 0;
  localparam int unsigned PKT_X_LSB      = 8;
  localparam int unsigned PKT_Y_LSB      = 16;
  localparam int unsigned SYNC_BIT       = 3;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] d,
                                         input logic                     p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line.
//   2-flop synchroniser, then a stability filter: the filtered value follows
//   the synchronised value only after FILT_LEN consecutive differing samples.
//   Optional one-cycle falling-edge pulse of the filtered value (EDGE_EN).
// Ports:
//   clk_i, rst_ni : clock, async active-low reset (line resets to idle-high)
//   line_i        : raw asynchronous line
//   filt_o        : filtered line level
//   fall_o        : one-cycle pulse when filt_o goes 1 -> 0 (0 if !EDGE_EN)
module ps2_line_filter #(
  parameter int unsigned FILT_LEN = 8,
  parameter bit          EDGE_EN  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;
  logic             fall_q;

  // Counter tracks how long the synchronised level has disagreed with filt_q.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], line_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= EDGE_EN & filt_q & ~filt_d;
    end
  end

  assign filt_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: PS/2 mouse receiver. Deserialises 11-bit PS/2 frames with
// start/parity/stop checking, assembles three accepted bytes into one packet
// and abandons partial frames/packets after TIMEOUT_CYC quiet cycles.
// Ports:
//   clk_sys, rst_n : system clock, async active-low reset
//   ps2_clk_in     : raw PS/2 clock
//   ps2_data_in    : raw PS/2 data
//   ps2pkg_vlk     : one-cycle strobe, ps2pkg_data holds a new packet
//   ps2pkg_data    : {Y, X, status}
//   frame_err      : one-cycle strobe on frame, sync-bit or timeout error
//   err_cnt        : saturating frame_err counter (only with PS2_ERR_CNT_EN)
// Optional feature macro: PS2_ERR_CNT_EN
module ps2_mouse_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILT_LEN    = 8,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic        ps2pkg_vlk,
  output logic [23:0] ps2pkg_data,
  output logic        frame_err
`ifdef PS2_ERR_CNT_EN
  ,
  output logic [7:0]  err_cnt
`endif
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);

  logic fall, data_bit, clk_filt_unused, data_fall_unused;

  ps2_line_filter #(.FILT_LEN(FILT_LEN), .EDGE_EN(1'b1)) u_clk_filt (
    .clk_i (clk_sys), .rst_ni (rst_n), .line_i (ps2_clk_in),
    .filt_o(clk_filt_unused), .fall_o(fall)
  );

  ps2_line_filter #(.FILT_LEN(FILT_LEN), .EDGE_EN(1'b0)) u_data_filt (
    .clk_i (clk_sys), .rst_ni (rst_n), .line_i (ps2_data_in),
    .filt_o(data_bit), .fall_o(data_fall_unused)
  );

  frame_state_t           state_q, state_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shift_q, shift_d, byte0_q, byte0_d, byte1_q, byte1_d;
  logic                   par_q, par_d;
  logic [1:0]             idx_q, idx_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   vlk_q, vlk_d, err_q, err_d;
  logic [PKT_W-1:0]       pkt_q, pkt_d;
  logic                   timeout_hit;

  // Timeout fires once, on the cycle the counter reaches TIMEOUT_CYC while busy.
  assign timeout_hit = !fall && (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) &&
                       ((state_q != IDLE) || (idx_q != 2'd0));

  // Frame FSM state register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Frame FSM next state: advances only on the filtered clock falling edge.
  always_comb begin
    state_d = state_q;
    if (fall) begin
      case (state_q)
        IDLE:    if (!data_bit) state_d = DATA;
        DATA:    if (bit_cnt_q == BIT_W'(PS2_DATA_BITS - 1)) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = IDLE;
    end
  end

  // Datapath and output next values: shifter, byte index, packet, strobes.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    idx_d     = idx_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    pkt_d     = pkt_q;
    vlk_d     = 1'b0;
    err_d     = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end

    if (fall) begin
      case (state_q)
        IDLE: bit_cnt_d = '0;
        DATA: begin
          shift_d   = {data_bit, shift_q[PS2_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
        PARITY: par_d = data_bit;
        STOP: begin
          if (data_bit && odd_parity_ok(shift_q, par_q)) begin
            case (idx_q)
              2'd0: begin
                // A first byte without the sync bit is dropped to resync.
                if (shift_q[SYNC_BIT]) begin
                  byte0_d = shift_q;
                  idx_d   = 2'd1;
                end else begin
                  err_d = 1'b1;
                end
              end
              2'd1: begin
                byte1_d = shift_q;
                idx_d   = 2'd2;
              end
              default: begin
                pkt_d[PKT_STATUS_LSB +: PS2_DATA_BITS] = byte0_q;
                pkt_d[PKT_X_LSB      +: PS2_DATA_BITS] = byte1_q;
                pkt_d[PKT_Y_LSB      +: PS2_DATA_BITS] = shift_q;
                vlk_d = 1'b1;
                idx_d = 2'd0;
              end
            endcase
          end else begin
            err_d = 1'b1;
            idx_d = 2'd0;
          end
        end
        default: ;
      endcase
    end else if (timeout_hit) begin
      idx_d = 2'd0;
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      idx_q     <= 2'd0;
      byte0_q   <= '0;
      byte1_q   <= '0;
      to_cnt_q  <= '0;
      pkt_q     <= '0;
      vlk_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      idx_q     <= idx_d;
      byte0_q   <= byte0_d;
      byte1_q   <= byte1_d;
      to_cnt_q  <= to_cnt_d;
      pkt_q     <= pkt_d;
      vlk_q     <= vlk_d;
      err_q     <= err_d;
    end
  end

  assign ps2pkg_vlk  = vlk_q;
  assign ps2pkg_data = pkt_q;
  assign frame_err   = err_q;

`ifdef PS2_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  // Saturating count of frame_err pulses.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 8'h00;
    end else if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'h01;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// tb_ps2_mouse_rx: drives PS/2 frames into ps2_mouse_rx and compares strobes
// and packets against a byte-level packet model.
module tb_ps2_mouse_rx;

  localparam int unsigned FILT = 8;
  localparam int unsigned TO   = 1000;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic        vlk;
  logic [23:0] pdata;
  logic        ferr;
`ifdef PS2_ERR_CNT_EN
  logic [7:0]  err_cnt;
`endif

  always #10 clk_sys = ~clk_sys;

  ps2_mouse_rx #(.FILT_LEN(FILT), .TIMEOUT_CYC(TO)) dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .ps2_clk_in (ps2_clk),
    .ps2_data_in(ps2_dat),
    .ps2pkg_vlk (vlk),
    .ps2pkg_data(pdata),
    .frame_err  (ferr)
`ifdef PS2_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  int half   = 20;

  // Cycle counter and output monitor (sampled on the falling edge).
  int unsigned cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int unsigned fall_cyc = 0, vlk_cyc = 0;
  int          vlk_cnt = 0, ferr_cnt = 0, wide_vlk = 0, silent_chg = 0;
  logic        vlk_prev = 1'b0;
  logic [23:0] data_prev = 24'h0;
  logic [23:0] got_q[$];

  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (vlk) begin
        vlk_cnt++;
        got_q.push_back(pdata);
        vlk_cyc = cyc;
      end
      if (vlk && vlk_prev) wide_vlk++;
      if (ferr) ferr_cnt++;
      if ((pdata !== data_prev) && !vlk) silent_chg++;
    end
    vlk_prev  = vlk;
    data_prev = pdata;
  end

  // Packet model: byte stream -> expected packets and error count.
  int          exp_idx = 0, exp_vlk = 0, exp_err = 0;
  logic [7:0]  mb0, mb1;
  logic [23:0] exp_q[$];

  task automatic model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      exp_err++;
      exp_idx = 0;
    end else if (exp_idx == 0) begin
      if (b[3]) begin mb0 = b; exp_idx = 1; end
      else exp_err++;
    end else if (exp_idx == 1) begin
      mb1 = b; exp_idx = 2;
    end else begin
      exp_q.push_back({b, mb1, mb0});
      exp_vlk++;
      exp_idx = 0;
    end
  endtask

  task automatic model_timeout();
    if (exp_idx != 0) begin
      exp_err++;
      exp_idx = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] e, g;
    chk({tag, "_vlk_cnt"}, vlk_cnt, exp_vlk);
    chk({tag, "_err_cnt"}, ferr_cnt, exp_err);
    chk({tag, "_vlk_width"}, wide_vlk, 0);
    chk({tag, "_silent_data"}, silent_chg, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 24'hxxxxxx;
      chk({tag, "_pkt"}, {8'h0, g}, {8'h0, e});
    end
    got_q.delete();
  endtask

  // One PS/2 bit: data changes while the clock is high, sampled on the fall.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      repeat (4) @(negedge clk_sys);
      ps2_clk = 1'b0;
      repeat (FILT - 1) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (half) @(negedge clk_sys);
    end else begin
      repeat (half) @(negedge clk_sys);
    end
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (half) @(negedge clk_sys);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip,
                            input bit stop_bad, input bit glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 2 || i == 5));
    send_bit((~^b) ^ par_flip, 1'b0);
    send_bit(~stop_bad, 1'b0);
    ps2_dat = 1'b1;
    repeat (half) @(negedge clk_sys);
    model_byte(b, !(par_flip || stop_bad));
  endtask

  task automatic send_pkt(input logic [7:0] b0, b1, b2, input bit glitch);
    send_frame(b0, 1'b0, 1'b0, glitch);
    send_frame(b1, 1'b0, 1'b0, glitch);
    send_frame(b2, 1'b0, 1'b0, glitch);
  endtask

  initial begin
    #(10_000_000);
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb[3];
    int         kind, j;

    // Reset state
    repeat (5) @(negedge clk_sys);
    chk("rst_vlk", vlk, 0);
    chk("rst_data", pdata, 0);
    chk("rst_err", ferr, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_sys);

    // Basic packet and strobe latency after the final stop-bit fall
    send_pkt(8'h08, 8'h12, 8'hF0, 1'b0);
    chk("t1_latency_ok", ((vlk_cyc - fall_cyc) >= FILT + 2) && ((vlk_cyc - fall_cyc) <= FILT + 5), 1);
    chk("t1_data", pdata, 24'hF01208);
    check_all("t1");

    // Parity error on byte 1, then a valid packet
    send_frame(8'h08, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    check_all("t2a");
    send_pkt(8'h18, 8'h01, 8'h02, 1'b0);
    chk("t2_data", pdata, 24'h020118);
    check_all("t2b");

    // Stray first byte without sync bit
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    send_pkt(8'h28, 8'h05, 8'hFB, 1'b0);
    check_all("t3");

    // Timeout after two bytes
    send_frame(8'h09, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    repeat (TO + 10) @(negedge clk_sys);
    model_timeout();
    chk("t4_timeout_err", ferr_cnt, exp_err);
    send_pkt(8'h3C, 8'h7F, 8'h80, 1'b0);
    check_all("t4");

    // Sub-filter clock glitches inside frames
    send_pkt(8'h0A, 8'hA5, 8'h5A, 1'b1);
    check_all("t5");

    // Reset during byte 1
    send_frame(8'h08, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    @(posedge clk_sys);
    #2 rst_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    exp_idx = 0;
    repeat (3) @(negedge clk_sys);
    chk("t6_rst_vlk", vlk, 0);
    chk("t6_rst_data", pdata, 0);
    chk("t6_rst_err", ferr, 0);
`ifdef PS2_ERR_CNT_EN
    chk("t6_rst_errcnt", err_cnt, 0);
`endif
    @(posedge clk_sys);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk_sys);
    send_pkt(8'h29, 8'h44, 8'hC3, 1'b0);
    check_all("t6");

    // Randomized packets with occasional injected faults
    for (int p = 0; p < 8; p++) begin
      for (int k = 0; k < 3; k++) rb[k] = 8'($urandom);
      rb[0][3] = 1'b1;
      kind = int'($urandom_range(0, 3));
      j    = int'($urandom_range(0, 2));
      if (kind == 3) rb[0][3] = 1'b0;
      for (int k = 0; k < 3; k++)
        send_frame(rb[k], (kind == 1) && (k == j), (kind == 2) && (k == j), 1'b0);
    end
    repeat (TO + 20) @(negedge clk_sys);
    model_timeout();
    check_all("rnd");

`ifdef PS2_ERR_CNT_EN
    // Saturating error counter
    half = 10;
    for (int k = 0; k < 300; k++) send_frame(8'($urandom), 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk_sys);
    chk("errcnt_sat", err_cnt, 8'hFF);
    check_all("errcnt");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
